// File: rtl/pixel_readback_pkg.sv
// Shared constants, state encoding and address helpers for the pixel
// readback shadow memory.
package pixel_readback_pkg;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = 19200;
  localparam int ADDR_W   = 15;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COL_W    = 3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD1   = 2'd1,
    RD2   = 2'd2,
    CLEAR = 2'd3
  } state_e;

  // y*160 + x built from shifts so no multiplier is needed.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] yw;
    logic [ADDR_W-1:0] xw;
    yw = {{(ADDR_W-Y_W){1'b0}}, y};
    xw = {{(ADDR_W-X_W){1'b0}}, x};
    pix_addr = (yw << 7) + (yw << 5) + xw;
  endfunction

  function automatic logic in_range(input logic [X_W-1:0] x,
                                    input logic [Y_W-1:0] y);
    in_range = (x < X_W'(FB_W)) && (y < Y_W'(FB_H));
  endfunction

endpackage

// File: rtl/pixel_readback_if.sv
// Plot/read/clear bundle between a pixel producer and the readback block.
// Read handshake: a read transfers on a rising edge where rd_req=1 and
// rd_ready=1; the requester holds rd_req, rd_x and rd_y stable until then.
// rd_valid is a single-cycle pulse two cycles after that edge and carries no
// back-pressure; rd_colour/rd_oob hold their value between pulses.
interface pixel_readback_if;
  import pixel_readback_pkg::*;

  logic [X_W-1:0]   wr_x;
  logic [Y_W-1:0]   wr_y;
  logic [COL_W-1:0] wr_colour;
  logic             wr_plot;
  logic             rd_req;
  logic [X_W-1:0]   rd_x;
  logic [Y_W-1:0]   rd_y;
  logic             rd_ready;
  logic             rd_valid;
  logic [COL_W-1:0] rd_colour;
  logic             rd_oob;
  logic             clear;
  logic             busy;

  modport master (
    output wr_x, wr_y, wr_colour, wr_plot, rd_req, rd_x, rd_y, clear,
    input  rd_ready, rd_valid, rd_colour, rd_oob, busy
  );

  modport slave (
    input  wr_x, wr_y, wr_colour, wr_plot, rd_req, rd_x, rd_y, clear,
    output rd_ready, rd_valid, rd_colour, rd_oob, busy
  );

endinterface

// File: rtl/pixel_readback_ram.sv
// Simple dual-port framebuffer shadow: one write port, one synchronous read
// port, no reset. A same-edge read of the written address returns old data.
module pixel_ram #(
  parameter int DEPTH = 19200,
  parameter int AW    = 15,
  parameter int DW    = 3
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port and registered read port share the clock.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pixel_readback.sv
// 160x120 3-bit shadow of the VGA framebuffer with a two-cycle read port
// and a full-memory clear sweep. Define PIXEL_READBACK_FWD_EN to forward
// writes that land on the read address during the accept cycle or the one
// after it.
module pixel_readback
  import pixel_readback_pkg::*;
#(
  parameter logic [COL_W-1:0] BG_COLOUR = 3'b000
) (
  input  logic             Clock,
  input  logic             Resetn,
  pixel_readback_if.slave  pix,
  output state_e           state_o
);

  state_e            state_q, state_d;
  logic              clr_pend_q, clr_pend_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              req_oob_q, req_oob_d;
  logic              rd_valid_q, rd_valid_d;
  logic [COL_W-1:0]  rd_colour_q, rd_colour_d;
  logic              rd_oob_q, rd_oob_d;

  logic              wr_ok, rd_ok, ext_we, rd_ready, accept;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [COL_W-1:0]  ram_wdata, ram_rdata, rd_data;

  assign wr_ok   = in_range(pix.wr_x, pix.wr_y);
  assign rd_ok   = in_range(pix.rd_x, pix.rd_y);
  assign wr_addr = pix_addr(pix.wr_x, pix.wr_y);
  assign rd_addr = pix_addr(pix.rd_x, pix.rd_y);

  // External plots are ignored while the sweep owns the write port.
  assign ext_we   = pix.wr_plot && wr_ok && (state_q != CLEAR);
  // A clear on the same cycle as a request takes priority over the read.
  assign rd_ready = (state_q == IDLE) && !clr_pend_q && !pix.clear;
  assign accept   = pix.rd_req && rd_ready;

  assign ram_we    = (state_q == CLEAR) || ext_we;
  assign ram_waddr = (state_q == CLEAR) ? clr_addr_q : wr_addr;
  assign ram_wdata = (state_q == CLEAR) ? BG_COLOUR : pix.wr_colour;

  pixel_ram #(
    .DEPTH (FB_DEPTH),
    .AW    (ADDR_W),
    .DW    (COL_W)
  ) u_ram (
    .clk_i   (Clock),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (accept && rd_ok),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

`ifdef PIXEL_READBACK_FWD_EN
  logic [ADDR_W-1:0] rd_addr_q;
  logic              fwd_hit_q;
  logic [COL_W-1:0]  fwd_col_q;

  // Capture the read address and any same-cycle write that hits it.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      rd_addr_q <= '0;
      fwd_hit_q <= 1'b0;
      fwd_col_q <= '0;
    end else if (accept) begin
      rd_addr_q <= rd_addr;
      fwd_hit_q <= ext_we && (wr_addr == rd_addr);
      fwd_col_q <= pix.wr_colour;
    end
  end

  // A hit during RD1 is newer than one captured at accept time.
  assign rd_data = (ext_we && (wr_addr == rd_addr_q)) ? pix.wr_colour :
                   fwd_hit_q                          ? fwd_col_q     :
                                                        ram_rdata;
`else
  assign rd_data = ram_rdata;
`endif

  // Sequencing of reads and clear sweeps, plus the registered read result.
  always_comb begin
    state_d     = state_q;
    clr_pend_d  = clr_pend_q;
    clr_addr_d  = clr_addr_q;
    req_oob_d   = req_oob_q;
    rd_valid_d  = 1'b0;
    rd_colour_d = rd_colour_q;
    rd_oob_d    = rd_oob_q;
    case (state_q)
      IDLE: begin
        if (pix.clear || clr_pend_q) begin
          state_d    = CLEAR;
          clr_pend_d = 1'b0;
          clr_addr_d = '0;
        end else if (accept) begin
          state_d   = RD1;
          req_oob_d = !rd_ok;
        end
      end
      RD1: begin
        state_d     = RD2;
        rd_valid_d  = 1'b1;
        rd_oob_d    = req_oob_q;
        rd_colour_d = req_oob_q ? '0 : rd_data;
        if (pix.clear) clr_pend_d = 1'b1;
      end
      RD2: begin
        if (clr_pend_q || pix.clear) begin
          state_d    = CLEAR;
          clr_pend_d = 1'b0;
          clr_addr_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      clr_pend_q  <= 1'b0;
      clr_addr_q  <= '0;
      req_oob_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_colour_q <= '0;
      rd_oob_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_pend_q  <= clr_pend_d;
      clr_addr_q  <= clr_addr_d;
      req_oob_q   <= req_oob_d;
      rd_valid_q  <= rd_valid_d;
      rd_colour_q <= rd_colour_d;
      rd_oob_q    <= rd_oob_d;
    end
  end

  assign pix.rd_ready  = rd_ready;
  assign pix.rd_valid  = rd_valid_q;
  assign pix.rd_colour = rd_colour_q;
  assign pix.rd_oob    = rd_oob_q;
  assign pix.busy      = (state_q == CLEAR);
  assign state_o       = state_q;

endmodule

// File: tb/tb_pixel_readback.sv
// Bench for pixel_readback: directed cases plus randomized reads with
// collision writes, checked against an array model of the framebuffer.
module tb_pixel_readback;
  import pixel_readback_pkg::*;

  localparam logic [COL_W-1:0] BG = 3'b010;

  logic   Clock = 1'b0;
  logic   Resetn;
  state_e state_dbg;
  int     n_checks = 0;
  int     n_errors = 0;

  logic [COL_W-1:0]  model_mem [FB_DEPTH];
  logic [ADDR_W-1:0] swp_q[$];

  pixel_readback_if pix();

  pixel_readback #(.BG_COLOUR(BG)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .pix     (pix),
    .state_o (state_dbg)
  );

  // Clock and reset block
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit in_fb(input int x, input int y);
    return (x < FB_W) && (y < FB_H);
  endfunction

  function automatic int fb_addr(input int x, input int y);
    return y * FB_W + x;
  endfunction

  task automatic model_fill(input logic [COL_W-1:0] c);
    for (int i = 0; i < FB_DEPTH; i++) model_mem[i] = c;
  endtask

  // Driver tasks
  task automatic drive_write(input bit en, input int x, input int y, input logic [COL_W-1:0] c);
    pix.wr_plot   = en;
    pix.wr_x      = X_W'(x);
    pix.wr_y      = Y_W'(y);
    pix.wr_colour = c;
    if (en && in_fb(x, y)) model_mem[fb_addr(x, y)] = c;
  endtask

  task automatic write_px(input int x, input int y, input logic [COL_W-1:0] c);
    @(negedge Clock);
    drive_write(1'b1, x, y, c);
    @(negedge Clock);
    pix.wr_plot = 1'b0;
  endtask

  // One read with an optional write on the accept cycle (w0) and the next (w1).
  task automatic read_check(input string tag, input int rx, input int ry,
                            input bit w0 = 0, input int x0 = 0, input int y0 = 0,
                            input logic [COL_W-1:0] c0 = '0,
                            input bit w1 = 0, input int x1 = 0, input int y1 = 0,
                            input logic [COL_W-1:0] c1 = '0);
    logic [COL_W-1:0] exp_c;
    bit oob;
    @(negedge Clock);
    pix.rd_req = 1'b1;
    pix.rd_x   = X_W'(rx);
    pix.rd_y   = Y_W'(ry);
    oob   = !in_fb(rx, ry);
    exp_c = oob ? '0 : model_mem[fb_addr(rx, ry)];
    drive_write(w0, x0, y0, c0);
    #1 check({tag, "_rdy"}, pix.rd_ready, 1);
    @(negedge Clock);
    pix.rd_req = 1'b0;
    drive_write(w1, x1, y1, c1);
    check({tag, "_lat"}, pix.rd_valid, 0);
    @(negedge Clock);
    pix.wr_plot = 1'b0;
`ifdef PIXEL_READBACK_FWD_EN
    if (!oob) exp_c = model_mem[fb_addr(rx, ry)];
`endif
    check({tag, "_vld"}, pix.rd_valid, 1);
    check({tag, "_col"}, pix.rd_colour, exp_c);
    check({tag, "_oob"}, pix.rd_oob, oob);
    @(negedge Clock);
    check({tag, "_pulse"}, pix.rd_valid, 0);
    check({tag, "_hold"}, pix.rd_colour, exp_c);
  endtask

  // Counts the sweep from a negedge where busy is already expected high,
  // throwing writes and read requests at it the whole time.
  task automatic sweep_wait(input string tag);
    int n = 0, rdy_bad = 0, vld_bad = 0, x, y;
    while (pix.busy === 1'b1 && n < 20000) begin
      n++;
      if (pix.rd_ready !== 1'b0) rdy_bad++;
      if (pix.rd_valid !== 1'b0) vld_bad++;
      x = $urandom_range(0, FB_W - 1);
      y = $urandom_range(0, FB_H - 1);
      pix.wr_plot   = 1'b1;
      pix.wr_x      = X_W'(x);
      pix.wr_y      = Y_W'(y);
      pix.wr_colour = 3'($urandom_range(0, 7));
      pix.rd_req    = 1'($urandom_range(0, 1));
      if (n > 19000 && n <= 19006) swp_q.push_back(ADDR_W'(fb_addr(x, y)));
      @(negedge Clock);
    end
    pix.wr_plot = 1'b0;
    pix.rd_req  = 1'b0;
    check({tag, "_len"}, n, FB_DEPTH);
    check({tag, "_rdy0"}, rdy_bad, 0);
    check({tag, "_vld0"}, vld_bad, 0);
    model_fill(BG);
  endtask

  initial begin
    int rx, ry, vcnt;
    bit w0, w1;
    int x0, y0, x1, y1, sel;
    logic [ADDR_W-1:0] a;

    pix.rd_req = 1'b0; pix.rd_x = '0; pix.rd_y = '0; pix.clear = 1'b0;
    drive_write(1'b0, 0, 0, '0);
    Resetn = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_valid", pix.rd_valid, 0);
    check("rst_colour", pix.rd_colour, 0);
    check("rst_oob", pix.rd_oob, 0);
    check("rst_busy", pix.busy, 0);
    check("rst_state", state_dbg, IDLE);
    Resetn = 1'b1;
    #1 check("rst_ready", pix.rd_ready, 1);

    // Full clear, then corners, an interior pixel and late sweep writes.
    @(negedge Clock); pix.clear = 1'b1;
    @(negedge Clock); pix.clear = 1'b0;
    sweep_wait("clr1");
    read_check("bg00", 0, 0);
    read_check("bg_end", 159, 119);
    read_check("bg_mid", 77, 33);
    while (swp_q.size() > 0) begin
      a = swp_q.pop_front();
      read_check("swp_drop", int'(a) % FB_W, int'(a) / FB_W);
    end

    // Basic write then read.
    write_px(10, 20, 3'b101);
    repeat (5) @(negedge Clock);
    read_check("wr_rd", 10, 20);

    // Out-of-range reads and a dropped out-of-range write.
    read_check("oob_x", 160, 5);
    read_check("oob_y", 0, 120);
    write_px(200, 50, 3'b111);
    read_check("oob_wr", 40, 50);
    read_check("oob_alias", 40, 51);

    // Collisions on the accept cycle and the cycle after.
    write_px(5, 5, 3'b001);
    read_check("coll0", 5, 5, 1, 5, 5, 3'b111);
    write_px(6, 6, 3'b100);
    read_check("coll1", 6, 6, 0, 0, 0, '0, 1, 6, 6, 3'b011);

    // Clear arriving during RD1: read completes, sweep starts right after.
    write_px(3, 3, 3'b110);
    @(negedge Clock);
    pix.rd_req = 1'b1; pix.rd_x = 8'd3; pix.rd_y = 7'd3;
    #1 check("rdclr_rdy", pix.rd_ready, 1);
    @(negedge Clock);
    pix.rd_req = 1'b0; pix.clear = 1'b1;
    check("rdclr_lat", pix.rd_valid, 0);
    @(negedge Clock);
    pix.clear = 1'b0;
    check("rdclr_vld", pix.rd_valid, 1);
    check("rdclr_col", pix.rd_colour, 3'b110);
    check("rdclr_busy0", pix.busy, 0);
    @(negedge Clock);
    check("rdclr_busy1", pix.busy, 1);
    sweep_wait("clr2");
    read_check("rdclr_wiped", 3, 3);

    // Clear and request together, then reset part way through the sweep.
    write_px(0, 0, 3'b101);
    write_px(159, 119, 3'b110);
    @(negedge Clock);
    pix.clear = 1'b1; pix.rd_req = 1'b1; pix.rd_x = 8'd9; pix.rd_y = 7'd9;
    #1 check("clrwin_rdy", pix.rd_ready, 0);
    @(negedge Clock);
    pix.clear = 1'b0; pix.rd_req = 1'b0;
    check("clrwin_busy", pix.busy, 1);
    vcnt = 0;
    repeat (100) begin
      @(negedge Clock);
      if (pix.rd_valid !== 1'b0) vcnt++;
    end
    check("clrwin_novld", vcnt, 0);
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    check("abort_busy", pix.busy, 0);
    check("abort_vld", pix.rd_valid, 0);
    #1 check("abort_rdy", pix.rd_ready, 1);
    model_mem[0] = BG;
    read_check("abort_lo", 0, 0);
    read_check("abort_hi", 159, 119);

    // Reset while a read is in RD1.
    @(negedge Clock);
    pix.rd_req = 1'b1; pix.rd_x = 8'd159; pix.rd_y = 7'd119;
    @(negedge Clock);
    pix.rd_req = 1'b0;
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    vcnt = 0;
    repeat (3) begin
      if (pix.rd_valid !== 1'b0) vcnt++;
      @(negedge Clock);
    end
    check("rdrst_novld", vcnt, 0);
    check("rdrst_col", pix.rd_colour, 0);
    check("rdrst_busy", pix.busy, 0);
    #1 check("rdrst_rdy", pix.rd_ready, 1);

    // Randomized reads with optional colliding writes.
    for (int i = 0; i < 150; i++) begin
      rx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(160, 255)) : int'($urandom_range(0, 159));
      ry = ($urandom_range(0, 9) == 0) ? int'($urandom_range(120, 127)) : int'($urandom_range(0, 119));
      sel = $urandom_range(0, 2);
      w0 = (sel != 0);
      x0 = (sel == 1) ? rx : int'($urandom_range(0, 170));
      y0 = (sel == 1) ? ry : int'($urandom_range(0, 125));
      sel = $urandom_range(0, 2);
      w1 = (sel != 0);
      x1 = (sel == 1) ? rx : int'($urandom_range(0, 170));
      y1 = (sel == 1) ? ry : int'($urandom_range(0, 125));
      if ($urandom_range(0, 3) == 0)
        write_px($urandom_range(0, 159), $urandom_range(0, 119), 3'($urandom_range(0, 7)));
      read_check("rnd", rx, ry, w0, x0, y0, 3'($urandom_range(0, 7)),
                 w1, x1, y1, 3'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pixel_readback.md
PIXEL_READBACK -- requirements
Module: pixel_readback

Interface
REQ-001 Parameter: BG_COLOUR, 3'b000, colour written to every location by a clear sweep.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Resetn  input  1  reset, synchronous, active-low.
REQ-004 wr_x  input  8  plot column, mirrors the VGA adapter x input.
REQ-005 wr_y  input  7  plot row, mirrors the VGA adapter y input.
REQ-006 wr_colour  input  3  plot colour.
REQ-007 wr_plot  input  1  write strobe; the same signal drives the adapter plot input.
REQ-008 rd_req  input  1  read request; held until accepted.
REQ-009 rd_x  input  8  read column.
REQ-010 rd_y  input  7  read row.
REQ-011 rd_ready  output  1  block can accept a read this cycle.
REQ-012 rd_valid  output  1  one-cycle pulse; rd_colour and rd_oob are valid.
REQ-013 rd_colour  output  3  colour read back.
REQ-014 rd_oob  output  1  read coordinate was out of range.
REQ-015 clear  input  1  request to sweep the whole shadow memory to BG_COLOUR.
REQ-016 busy  output  1  clear sweep in progress.

Function
REQ-017 The block shall hold a 160x120 shadow of the 3-bit framebuffer at address y*160+x (15 bits), formed as (y<<7)+(y<<5)+x.
REQ-018 A write shall occur on every cycle with wr_plot=1, wr_x<160, wr_y<120 and state not CLEAR.
REQ-019 Writes with wr_x>=160 or wr_y>=120 shall be dropped.
REQ-020 A read shall be accepted on a cycle with rd_req=1 and rd_ready=1.
REQ-021 rd_ready shall be 1 only in state IDLE with no clear pending.
REQ-022 rd_valid shall pulse exactly 2 cycles after the accept edge; at most one read is outstanding.
REQ-023 An out-of-range read shall return rd_colour=0 and rd_oob=1 with the same latency; otherwise rd_oob=0.
REQ-024 rd_colour and rd_oob shall hold their last values while rd_valid=0.
REQ-025 FSM states: IDLE -> (accept) RD1 -> RD2 (rd_valid=1) -> IDLE or CLEAR if a clear is pending; IDLE -> (clear or pending) CLEAR; CLEAR -> IDLE after address 19199 is written.
REQ-026 A clear pulse arriving outside IDLE shall be latched as pending; a clear during CLEAR shall be ignored.
REQ-027 CLEAR shall write BG_COLOUR to addresses 0..19199 in order, one per cycle (19200 cycles), with busy=1 throughout.
REQ-028 External writes during CLEAR shall be dropped.
REQ-029 When clear and rd_req coincide in IDLE, clear shall win and the read shall not be accepted.
REQ-030 Without forwarding, a write and an accepted read to the same address on the same cycle shall return the old colour.

Reset
REQ-031 While Resetn=0 at a rising edge: state IDLE, pending clear 0, rd_valid 0, rd_colour 0, rd_oob 0, busy 0; rd_ready shall be 1 on the first cycle after release.
REQ-032 Reset during RD1/RD2 shall drop the read with no rd_valid pulse.
REQ-033 Reset during CLEAR shall abort the sweep; memory contents are not reset and stay partially cleared.

Configuration
REQ-034 With PIXEL_READBACK_FWD_EN defined, a valid write to the read address on the accept cycle or the following cycle shall be forwarded, and rd_colour shall return the newest written colour.
REQ-035 Without PIXEL_READBACK_FWD_EN, no forwarding logic shall exist and REQ-030 applies.

Structure
REQ-036 Package pixel_readback_pkg shall hold FB_W=160, FB_H=120, FB_DEPTH=19200, ADDR_W=15, the coordinate and colour widths, and the state enum {IDLE, RD1, RD2, CLEAR}.
REQ-037 Storage shall be one sub-module, pixel_ram: simple dual-port, 19200x3, one write port, synchronous read, no reset.

Verification
REQ-038 Write (10,20)=3'b101, read (10,20) 5 cycles later -> rd_valid 2 cycles after accept, rd_colour=101, rd_oob=0.
REQ-039 Read (160,5) and (0,120) -> rd_colour=000, rd_oob=1; write to (200,50) followed by a read of (40,50) -> contents unchanged.
REQ-040 Pulse clear with BG_COLOUR=3'b010 -> busy=1 for exactly 19200 cycles, rd_ready=0 throughout, then reads of (0,0), (159,119) and (77,33) -> 010; writes during the sweep are dropped.
REQ-041 clear asserted on the same cycle as an accepted read's RD1 -> the read completes with rd_valid, then CLEAR starts on the next cycle.
REQ-042 Write (5,5)=111 on the same cycle as the read accept of (5,5), with old value 001 -> returns 001 without the macro and 111 with PIXEL_READBACK_FWD_EN.
REQ-043 Resetn=0 for one cycle mid-read and mid-clear -> no rd_valid pulse, busy=0, rd_ready=1 on the next cycle.
